control_unit: RTL and testbench

//   RV32I subset control unit for the Decode stage. Opcode/funct3/funct7 feed a main decoder
//   and an ALU decoder; all control outputs are registered once on clk (decode pipeline register).

---
 rtl/control_unit.sv | 194 +++++++++++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// RV32I subset decode-stage control unit (lw, sw, R-type, I-type ALU, beq).
// Latency: 1 cycle; every control output is taken from the decode pipeline register.
// Backpressure: none. The unit decodes every cycle and has no stall or enable input.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset (clears all outputs)
//   Op/funct3/funct7  instruction fields [6:0], [14:12], [31:25]; only funct7[5] is used
//   RegWrite          register file write enable
//   ImmSrc            immediate format: 00=I, 01=S, 10=B
//   ALUSrc            ALU operand B: 0=register, 1=immediate
//   MemWrite          data memory write enable
//   ResultSrc         writeback select: 0=ALU result, 1=memory read data
//   Branch            conditional branch
//   ALUControl        000 add, 001 sub, 010 and, 011 or, 101 slt
//   IllegalOp         only when CU_ILLEGAL_OP_EN is defined: unsupported opcode or
//                     unsupported funct3 for an ALU-class instruction
module control_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic       ResultSrc,
    output logic       Branch,
`ifdef CU_ILLEGAL_OP_EN
    output logic [2:0] ALUControl,
    output logic       IllegalOp
`else
    output logic [2:0] ALUControl
`endif
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Only funct7[5] distinguishes add/sub; the remaining bits are don't-care.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    logic       reg_write_d;
    logic [1:0] imm_src_d;
    logic       alu_src_d;
    logic       mem_write_d;
    logic       result_src_d;
    logic       branch_d;
    logic [1:0] alu_op;
    logic       op_known;

    always_comb begin
        reg_write_d  = 1'b0;
        imm_src_d    = 2'b00;
        alu_src_d    = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = 1'b0;
        branch_d     = 1'b0;
        alu_op       = 2'b00;
        op_known     = 1'b1;
        // An X or unlisted opcode matches no item and falls to the all-zero row.
        case (Op)
            OP_LW: begin
                reg_write_d  = 1'b1;
                alu_src_d    = 1'b1;
                result_src_d = 1'b1;
            end
            OP_SW: begin
                imm_src_d   = 2'b01;
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            OP_R: begin
                reg_write_d = 1'b1;
                alu_op      = 2'b10;
            end
            OP_IALU: begin
                reg_write_d = 1'b1;
                alu_src_d   = 1'b1;
                alu_op      = 2'b10;
            end
            OP_BEQ: begin
                imm_src_d = 2'b10;
                branch_d  = 1'b1;
                alu_op    = 2'b01;
            end
            default: op_known = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder
    // ------------------------------------------------------------------
    logic [2:0] alu_ctrl_d;
    logic       funct3_known;

    always_comb begin
        alu_ctrl_d   = ALU_ADD;
        funct3_known = 1'b1;
        case (alu_op)
            2'b00: alu_ctrl_d = ALU_ADD;
            2'b01: alu_ctrl_d = ALU_SUB;
            2'b10: begin
                case (funct3)
                    // Op[5] separates R-type from I-type, so addi never subtracts
                    // even when its immediate happens to set bit 30.
                    3'b000:  alu_ctrl_d = ({Op[5], funct7[5]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl_d = ALU_SLT;
                    3'b110:  alu_ctrl_d = ALU_OR;
                    3'b111:  alu_ctrl_d = ALU_AND;
                    default: begin
                        alu_ctrl_d   = ALU_ADD;
                        funct3_known = 1'b0;
                    end
                endcase
            end
            default: alu_ctrl_d = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Decode pipeline register
    // ------------------------------------------------------------------
    logic       reg_write_q;
    logic [1:0] imm_src_q;
    logic       alu_src_q;
    logic       mem_write_q;
    logic       result_src_q;
    logic       branch_q;
    logic [2:0] alu_ctrl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_q  <= 1'b0;
            imm_src_q    <= 2'b00;
            alu_src_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 3'b000;
        end else begin
            reg_write_q  <= reg_write_d;
            imm_src_q    <= imm_src_d;
            alu_src_q    <= alu_src_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
        end
    end

    assign RegWrite   = reg_write_q;
    assign ImmSrc     = imm_src_q;
    assign ALUSrc     = alu_src_q;
    assign MemWrite   = mem_write_q;
    assign ResultSrc  = result_src_q;
    assign Branch     = branch_q;
    assign ALUControl = alu_ctrl_q;

`ifdef CU_ILLEGAL_OP_EN
    logic illegal_d;
    logic illegal_q;

    assign illegal_d = !op_known || ((alu_op == 2'b10) && !funct3_known);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;
`else
    // Without the illegal-op output these qualifiers have no consumer.
    logic unused_known;
    assign unused_known = op_known ^ funct3_known;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

`ifdef CU_ILLEGAL_OP_EN
    localparam int W = 11;
`else
    localparam int W = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       RegWrite;
    logic [1:0] ImmSrc;
    logic       ALUSrc;
    logic       MemWrite;
    logic       ResultSrc;
    logic       Branch;
    logic [2:0] ALUControl;
`ifdef CU_ILLEGAL_OP_EN
    logic       IllegalOp;
`endif

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .RegWrite   (RegWrite),
        .ImmSrc     (ImmSrc),
        .ALUSrc     (ALUSrc),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .Branch     (Branch),
`ifdef CU_ILLEGAL_OP_EN
        .ALUControl (ALUControl),
        .IllegalOp  (IllegalOp)
`else
        .ALUControl (ALUControl)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl[, IllegalOp]}.
    logic [W-1:0] obs;
`ifdef CU_ILLEGAL_OP_EN
    assign obs = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl, IllegalOp};
`else
    assign obs = {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUControl};
`endif

    // Reference model: classify the instruction, then derive each control from its meaning.
    function automatic logic [W-1:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bit is_lw, is_sw, is_r, is_i, is_beq, is_alu, f3_ok, illegal;
        logic [1:0] imm;
        logic [2:0] aluc;
        is_lw  = (op == 7'h03);
        is_sw  = (op == 7'h23);
        is_r   = (op == 7'h33);
        is_i   = (op == 7'h13);
        is_beq = (op == 7'h63);
        is_alu = is_r || is_i;
        imm    = is_sw ? 2'd1 : (is_beq ? 2'd2 : 2'd0);
        f3_ok  = (f3 == 3'd0) || (f3 == 3'd2) || (f3 == 3'd6) || (f3 == 3'd7);
        aluc   = 3'd0;
        if (is_beq) aluc = 3'd1;                              // compare by subtraction
        else if (is_alu) begin
            if (f3 == 3'd0 && is_r && f7[5]) aluc = 3'd1;     // sub only for R-type
            else if (f3 == 3'd2) aluc = 3'd5;                 // slt
            else if (f3 == 3'd6) aluc = 3'd3;                 // or
            else if (f3 == 3'd7) aluc = 3'd2;                 // and
        end
        illegal = !(is_lw || is_sw || is_alu || is_beq) || (is_alu && !f3_ok);
`ifdef CU_ILLEGAL_OP_EN
        return {1'(is_lw || is_alu), imm, 1'(is_lw || is_sw || is_i), 1'(is_sw),
                1'(is_lw), 1'(is_beq), aluc, 1'(illegal)};
`else
        if (illegal) aluc = aluc;  // no illegal output in this build
        return {1'(is_lw || is_alu), imm, 1'(is_lw || is_sw || is_i), 1'(is_sw),
                1'(is_lw), 1'(is_beq), aluc};
`endif
    endfunction

    task automatic check(input string tag, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs away from the edge, then check just after the next rising edge.
    task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(negedge clk);
        Op = op; funct3 = f3; funct7 = f7;
        @(posedge clk);
        #1;
        check(tag, model(op, f3, f7));
    endtask

    initial begin
        logic [6:0] op_r;
        logic [2:0] f3_r;
        logic [6:0] f7_r;
        logic [6:0] known_ops [5];
        logic [6:0] seq_ops [3];
        known_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63};
        seq_ops   = '{7'h03, 7'h33, 7'h63};

        // Reset held: lw on the inputs with clock running must not leak through.
        rst_n = 1'b0; Op = 7'b0000011; funct3 = 3'd0; funct7 = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", '0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", '0);

        // Main decode, one-edge latency.
        step("lw",  7'b0000011, 3'b010, 7'd0);
        step("sw",  7'b0100011, 3'b010, 7'd0);
        step("beq", 7'b1100011, 3'b000, 7'd0);

        // Async clear mid-cycle while outputs are non-zero (beq loaded).
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", '0);
        @(negedge clk);
        rst_n = 1'b1;
        step("first_after_reset", 7'b0000011, 3'b010, 7'd0);

        // R-type ALU decode.
        step("r_sub", 7'b0110011, 3'b000, 7'b0100000);
        step("r_add", 7'b0110011, 3'b000, 7'b0000000);
        step("r_slt", 7'b0110011, 3'b010, 7'b0000000);
        step("r_or",  7'b0110011, 3'b110, 7'b0000000);
        step("r_and", 7'b0110011, 3'b111, 7'b0000000);

        // addi with funct7[5] set still adds.
        step("addi_no_sub", 7'b0010011, 3'b000, 7'b0100000);

        // Unsupported encodings.
        step("op_zero",   7'b0000000, 3'b000, 7'd0);
        step("r_funct3_001", 7'b0110011, 3'b001, 7'd0);
        step("i_funct3_100", 7'b0010011, 3'b100, 7'd0);

        // X opcode falls to the default row.
        @(negedge clk);
        Op = 7'bx; funct3 = 3'd0; funct7 = 7'd0;
        @(posedge clk);
        #1;
`ifdef CU_ILLEGAL_OP_EN
        check("op_x", W'(1));
`else
        check("op_x", '0);
`endif

        // lw/R/beq alternating every cycle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step("seq", seq_ops[i % 3], 3'($urandom_range(0, 7)), 7'($urandom));
        end

        // Random mix of supported and arbitrary encodings.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) op_r = known_ops[$urandom_range(0, 4)];
            else                           op_r = 7'($urandom);
            f3_r = 3'($urandom);
            f7_r = 7'($urandom);
            step("rand", op_r, f3_r, f7_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
